// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative MULU/DIVU.
// Results and flags are registered behind a valid/ready handshake.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero_flag,
  output logic             overflow_flag,
  output logic             div_by_zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MULU = 4'b1011;
  localparam logic [3:0] OP_DIVU = 4'b1100;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t               state_reg, state_next;
  logic [2*WIDTH-1:0]   acc_reg, acc_next;
  logic [WIDTH-1:0]     opb_reg, opb_next;
  logic [SHW-1:0]       count_reg, count_next;
  logic                 out_valid_reg, out_valid_next;
  logic [WIDTH-1:0]     result_reg, result_next;
  logic [WIDTH-1:0]     result_hi_reg, result_hi_next;
  logic                 zero_reg, zero_next;
  logic                 ovf_reg, ovf_next;
  logic                 dbz_reg, dbz_next;

  logic [WIDTH-1:0]     add_res, sub_res, single_res;
  logic                 single_ovf;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step;
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   div_step;
  logic                 last_iter;

  assign add_res = operand1 + operand2;
  assign sub_res = operand1 - operand2;

  always_comb begin
    single_res = '0;
    single_ovf = 1'b0;
    case (ALUControl)
      OP_AND:  single_res = operand1 & operand2;
      OP_OR:   single_res = operand1 | operand2;
      OP_ADD: begin
        single_res = add_res;
        single_ovf = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                     (add_res[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_XOR:  single_res = operand1 ^ operand2;
      OP_NOR:  single_res = ~(operand1 | operand2);
      OP_SRL:  single_res = operand1 >> shamt;
      OP_SUB: begin
        single_res = sub_res;
        single_ovf = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                     (sub_res[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SLL:  single_res = operand1 << shamt;
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
      OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (operand1 < operand2)};
      OP_SRA:  single_res = $unsigned($signed(operand1) >>> shamt);
      default: single_res = '0;
    endcase
  end

  // Shift-add: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opb_reg} : '0);
  assign mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

  // Restoring divide: acc = {remainder, dividend bits shifting into quotient}.
  assign div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
  assign div_ge    = div_shift >= {1'b0, opb_reg};
  assign div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opb_reg) : div_shift[WIDTH-1:0];
  assign div_step  = {div_rem, acc_reg[WIDTH-2:0], div_ge};

  assign last_iter = (count_reg == SHW'(WIDTH-1));

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    opb_next       = opb_reg;
    count_next     = count_reg;
    out_valid_next = 1'b0;
    result_next    = result_reg;
    result_hi_next = result_hi_reg;
    zero_next      = zero_reg;
    ovf_next       = ovf_reg;
    dbz_next       = dbz_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (ALUControl == OP_MULU || (ALUControl == OP_DIVU && operand2 != '0)) begin
            state_next = (ALUControl == OP_MULU) ? MUL : DIV;
            acc_next   = {{WIDTH{1'b0}}, operand1};
            opb_next   = operand2;
            count_next = '0;
          end else if (ALUControl == OP_DIVU) begin
            out_valid_next = 1'b1;
            result_next    = '1;
            result_hi_next = operand1;
            zero_next      = 1'b0;
            ovf_next       = 1'b0;
            dbz_next       = 1'b1;
          end else begin
            out_valid_next = 1'b1;
            result_next    = single_res;
            result_hi_next = '0;
            zero_next      = (single_res == '0);
            ovf_next       = single_ovf;
            dbz_next       = 1'b0;
          end
        end
      end
      MUL, DIV: begin
        acc_next   = (state_reg == MUL) ? mul_step : div_step;
        count_next = count_reg + SHW'(1);
        if (last_iter) begin
          state_next     = IDLE;
          count_next     = '0;
          out_valid_next = 1'b1;
          result_next    = acc_next[WIDTH-1:0];
          result_hi_next = acc_next[2*WIDTH-1:WIDTH];
          zero_next      = (acc_next[WIDTH-1:0] == '0);
          ovf_next       = 1'b0;
          dbz_next       = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      opb_reg       <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      result_hi_reg <= '0;
      zero_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      dbz_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      opb_reg       <= opb_next;
      count_reg     <= count_next;
      out_valid_reg <= out_valid_next;
      result_reg    <= result_next;
      result_hi_reg <= result_hi_next;
      zero_reg      <= zero_next;
      ovf_reg       <= ovf_next;
      dbz_reg       <= dbz_next;
    end
  end

  assign in_ready      = (state_reg == IDLE);
  assign out_valid     = out_valid_reg;
  assign result        = result_reg;
  assign result_hi     = result_hi_reg;
  assign zero_flag     = zero_reg;
  assign overflow_flag = ovf_reg;
  assign div_by_zero   = dbz_reg;

endmodule
